// File: rtl/pixel_thresh_seq_if.sv
// pixel_thresh_seq_if: control, source-read and destination-write signals of the thresholding sequencer.
interface pixel_thresh_seq_if #(parameter int AW = 8);
    logic          start;
    logic          restart;
    logic          rd_en;
    logic [7:0]    thresh;
    logic [7:0]    din;
    logic [AW-1:0] addr_rd;
    logic          wr_en;
    logic [AW-1:0] addr_wr;
    logic [7:0]    dout;
    logic [8:0]    count;
    logic          busy;
    logic          done;

    modport master (
        output start, restart, rd_en, thresh, din,
        input  addr_rd, wr_en, addr_wr, dout, count, busy, done
    );

    modport slave (
        input  start, restart, rd_en, thresh, din,
        output addr_rd, wr_en, addr_wr, dout, count, busy, done
    );
endinterface

// File: rtl/pixel_thresh_seq.sv
// pixel_thresh_seq: streams a frame from source BRAM, binarises each pixel against a latched threshold
// and writes it to destination BRAM; two-stage pipeline, stalled as a whole by rd_en.
module pixel_thresh_seq #(
    parameter int NPIX = 256,
    parameter int AW   = 8
) (
    input logic              clk,
    input logic              reset_n,
    pixel_thresh_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
    localparam logic [8:0]    FULL = 9'(NPIX);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_rd_q, addr_rd_d;
    logic [AW-1:0] a1_q, a1_d;
    logic [AW-1:0] addr_wr_q, addr_wr_d;
    logic          v1_q, v1_d;
    logic          wr_en_q, wr_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    thr_q, thr_d;
    logic [7:0]    dout_q, dout_d;
    logic [8:0]    count_q, count_d;

    always_comb begin
        state_d   = state_q;
        addr_rd_d = addr_rd_q;
        a1_d      = a1_q;
        addr_wr_d = addr_wr_q;
        v1_d      = v1_q;
        wr_en_d   = 1'b0;
        thr_d     = thr_q;
        dout_d    = dout_q;
        count_d   = count_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d   = RUN;
                thr_d     = bus.thresh;
                count_d   = '0;
                addr_rd_d = '0;
            end
            RUN, DRAIN: if (bus.rd_en) begin
                // din belongs to a1_q: the BRAM holds its output while rd_en is low, so stage 2 reads it directly
                v1_d      = state_q == RUN;
                a1_d      = addr_rd_q;
                wr_en_d   = v1_q;
                addr_wr_d = a1_q;
                dout_d    = bus.din >= thr_q ? 8'hFF : 8'h00;
                count_d   = count_q + {8'd0, v1_q};
                addr_rd_d = state_q == RUN && addr_rd_q != LAST ? addr_rd_q + 1'b1 : addr_rd_q;
                state_d   = state_q == RUN ? (addr_rd_q == LAST ? DRAIN : RUN)
                                           : (count_q == FULL ? DONE : DRAIN);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.restart) begin
            state_d   = IDLE;
            wr_en_d   = 1'b0;
            v1_d      = 1'b0;
            count_d   = '0;
            addr_rd_d = '0;
        end
        busy_d = state_d == RUN || state_d == DRAIN;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_rd_q <= '0;
            a1_q      <= '0;
            addr_wr_q <= '0;
            v1_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            thr_q     <= '0;
            dout_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_rd_q <= addr_rd_d;
            a1_q      <= a1_d;
            addr_wr_q <= addr_wr_d;
            v1_q      <= v1_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            thr_q     <= thr_d;
            dout_q    <= dout_d;
            count_q   <= count_d;
        end
    end

    assign bus.addr_rd = addr_rd_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.addr_wr = addr_wr_q;
    assign bus.dout    = dout_q;
    assign bus.count   = count_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_pixel_thresh_seq.sv
// tb_pixel_thresh_seq: directed frames against a source BRAM model with a write monitor.
module tb_pixel_thresh_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pixel_thresh_seq_if #(.AW(8)) bus();
    pixel_thresh_seq #(.NPIX(256), .AW(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [7:0] src [256];
    always_ff @(posedge clk) if (bus.rd_en) bus.din <= src[bus.addr_rd];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntest = 0, nfail = 0;
    int nwr, nff, bad_a, exp_addr, ndone, done_cyc, first_cyc, s_cyc;
    logic [7:0] d127, d128;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (nwr == 0) first_cyc = cyc;
            if (int'(bus.addr_wr) != exp_addr) bad_a++;
            if (bus.dout == 8'hFF) nff++;
            if (bus.addr_wr == 8'd127) d127 = bus.dout;
            if (bus.addr_wr == 8'd128) d128 = bus.dout;
            exp_addr++;
            nwr++;
        end
        if (bus.done) begin
            ndone++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntest++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        nwr = 0; nff = 0; bad_a = 0; exp_addr = 0; ndone = 0; done_cyc = 0; first_cyc = 0;
    endtask

    task automatic begin_frame(input logic [7:0] t);
        tick();
        clear_mon();
        bus.thresh = t;
        bus.start = 1'b1;
        s_cyc = cyc;
        tick();
        bus.start = 1'b0;
        bus.thresh = ~t;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (ndone == 0 && n < lim) begin
            tick();
            n++;
        end
        check("done_seen", ndone, 1);
    endtask

    task automatic wait_count(input logic [8:0] c, input int lim);
        int n = 0;
        while (bus.count != c && n < lim) begin
            tick();
            n++;
        end
        check("reach_count", bus.count, c);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_addr_rd"}, bus.addr_rd, 0);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.restart = 1'b0;
        bus.rd_en = 1'b1;
        bus.thresh = 8'd0;
        for (int i = 0; i < 256; i++) src[i] = 8'(i);
        clear_mon();
        tick(3);
        check_idle_zero("rst");
        check("rst_addr_wr", bus.addr_wr, 0);
        check("rst_dout", bus.dout, 0);
        reset_n = 1'b1;

        // full frame, ramp source, threshold 128
        begin_frame(8'd128);
        wait_done(400);
        check("full_done_cyc", done_cyc - s_cyc, 259);
        check("full_latency", first_cyc - s_cyc, 3);
        check("full_nwr", nwr, 256);
        check("full_order", bad_a, 0);
        check("full_nff", nff, 128);
        check("full_d127", d127, 8'h00);
        check("full_d128", d128, 8'hFF);
        tick();
        check("full_count_idle", bus.count, 256);
        check("full_busy_idle", bus.busy, 0);
        check("full_done_pulse", bus.done, 0);
        check("full_ndone", ndone, 1);

        // five-cycle stall at address 10
        begin_frame(8'd128);
        begin
            int n = 0;
            while (bus.addr_rd != 8'd10 && n < 50) begin
                tick();
                n++;
            end
        end
        check("stall_at", bus.addr_rd, 10);
        bus.rd_en = 1'b0;
        tick(3);
        check("stall_wr_en", bus.wr_en, 0);
        check("stall_addr_hold", bus.addr_rd, 10);
        tick(2);
        bus.rd_en = 1'b1;
        wait_done(400);
        check("stall_done_cyc", done_cyc - s_cyc, 264);
        check("stall_nwr", nwr, 256);
        check("stall_order", bad_a, 0);
        check("stall_nff", nff, 128);

        // boundary: pixel equal to threshold passes, one above fails; thresh is flipped mid-frame
        for (int i = 0; i < 256; i++) src[i] = 8'h7F;
        begin_frame(8'h7F);
        wait_done(400);
        check("eq_nff", nff, 256);
        check("eq_nwr", nwr, 256);
        begin_frame(8'h80);
        wait_done(400);
        check("gt_nff", nff, 0);
        check("gt_nwr", nwr, 256);

        // restart at count 100, then a clean frame
        for (int i = 0; i < 256; i++) src[i] = 8'(i);
        begin_frame(8'd128);
        wait_count(9'd100, 200);
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        check_idle_zero("abort");
        check("abort_nwr", nwr, 100);
        begin_frame(8'd128);
        wait_done(400);
        check("reframe_nwr", nwr, 256);
        check("reframe_order", bad_a, 0);
        check("reframe_nff", nff, 128);

        // restart beats start in IDLE; start is then taken next cycle
        tick();
        bus.restart = 1'b1;
        bus.start = 1'b1;
        tick();
        check("rs_prio_busy", bus.busy, 0);
        bus.restart = 1'b0;
        tick();
        check("rs_start_busy", bus.busy, 1);
        bus.start = 1'b0;
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        check("rs_abort_busy", bus.busy, 0);

        // start held high across the whole frame
        tick();
        clear_mon();
        bus.thresh = 8'd128;
        bus.start = 1'b1;
        s_cyc = cyc;
        wait_done(400);
        check("hold_done_cyc", done_cyc - s_cyc, 259);
        check("hold_nwr", nwr, 256);
        check("hold_order", bad_a, 0);
        tick(2);
        check("hold_second_busy", bus.busy, 1);
        check("hold_ndone", ndone, 1);
        bus.start = 1'b0;
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;

        // reset at count 50
        begin_frame(8'd128);
        wait_count(9'd50, 200);
        reset_n = 1'b0;
        tick();
        check_idle_zero("mrst");
        check("mrst_addr_wr", bus.addr_wr, 0);
        check("mrst_dout", bus.dout, 0);
        check("mrst_nwr", nwr, 50);
        reset_n = 1'b1;
        tick(2);
        check("mrst_stay_idle", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule

// File: doc/pixel_thresh_seq.md
PIXEL_THRESH_SEQ -- requirements
Module: pixel_thresh_seq

Interface
REQ-001 Parameter: NPIX, default 256, pixels per frame (16x16 image in source/destination BRAM).
REQ-002 Parameter: AW, default 8, BRAM address width; NPIX SHALL equal 2**AW.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 start  input  1  frame request; acted on only in IDLE.
REQ-006 restart  input  1  abort pulse from the control block (its read-side reset pulse); returns the block to IDLE.
REQ-007 rd_en  input  1  pipeline enable from the control block (source BRAM enable); 0 = stall.
REQ-008 thresh  input  8  binarisation threshold; sampled on frame start.
REQ-009 din  input  8  source BRAM read data; valid 1 cycle after addr_rd is presented with rd_en=1.
REQ-010 addr_rd  output  AW  source BRAM read address.
REQ-011 wr_en  output  1  destination BRAM write enable (wea).
REQ-012 addr_wr  output  AW  destination BRAM write address.
REQ-013 dout  output  8  destination BRAM write data.
REQ-014 count  output  9  pixels written this frame, 0..NPIX; consumed by the control block's completion compare (complete at count>=256).
REQ-015 busy  output  1  high in RUN and DRAIN.
REQ-016 done  output  1  one-cycle pulse when the frame is fully written.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE; all outputs registered.
REQ-018 IDLE -> RUN when start=1; thresh latched into thr_q; count cleared to 0; addr_rd set to 0.
REQ-019 RUN: each cycle with rd_en=1, addr_rd advances by 1; the address presented is tagged valid into stage 1.
REQ-020 RUN -> DRAIN in the cycle addr_rd=NPIX-1 is issued with rd_en=1; addr_rd holds NPIX-1 thereafter (no wrap to 0).
REQ-021 Stage 1 (rd_en=1): capture din and its address a1 with valid v1.
REQ-022 Stage 2 (rd_en=1): wr_en<=v1, addr_wr<=a1, dout<=(din_q>=thr_q)?8'hFF:8'h00.
REQ-023 Latency: address issued at cycle k (rd_en=1 continuously) -> wr_en=1 with that address at cycle k+2.
REQ-024 Stall: rd_en=0 freezes addr_rd, v1, a1, din_q, FSM state and count; wr_en=0 that cycle; no pixel lost or duplicated on resume.
REQ-025 count increments by 1 in every cycle wr_en=1; never exceeds NPIX (9-bit, 256 representable).
REQ-026 DRAIN -> DONE after the write of address NPIX-1 (count=NPIX).
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; count holds NPIX in IDLE until next start.
REQ-028 start while busy or in DONE: ignored, no effect on frame.
REQ-029 restart=1 in any state: next cycle IDLE, wr_en=0, v1=0, count=0, addr_rd=0, done=0; restart has priority over start and rd_en.
REQ-030 restart and start both high in IDLE: restart wins; start re-sampled on the following cycle.
REQ-031 thresh changes mid-frame SHALL not affect the frame in progress.

Reset
REQ-032 reset_n=0 at a rising edge: state=IDLE, addr_rd=0, addr_wr=0, dout=0, wr_en=0, count=0, busy=0, done=0, v1=0, thr_q=0; has priority over restart.
REQ-033 reset_n asserted mid-frame aborts with no further write; no write occurs in the reset cycle.

Verification
REQ-034 Full frame: src[i]=i, thresh=128, rd_en=1 -> 256 writes, addr_wr 0..255 ascending, dout=00 for i<128, FF for i>=128, done pulse at cycle 259 after start, count=256.
REQ-035 Stall: rd_en=0 for 5 cycles at addr_rd=10 -> exactly 256 writes, no duplicate/missing address, done delayed by 5 cycles.
REQ-036 Boundary: src all 8'h7F, thresh=8'h7F -> all dout=FF; thresh=8'h80 -> all dout=00.
REQ-037 Abort: restart pulse when count=100 -> next cycle IDLE, count=0, wr_en=0; new start yields clean full frame from address 0.
REQ-038 Ignored start: start held high throughout a frame -> single frame, one done pulse, then second frame begins from IDLE.
REQ-039 Reset: reset_n=0 at count=50 -> all outputs at reset values next cycle, no write issued.
